wb_user_io_ctrl: RTL and testbench

Parametrised Wishbone slave register block that sits inside the user project area, between the management-SoC Wishbone bus and the user IO pads, logic-analyzer lines and user IRQs.
- Provides software-controlled pad output and output-enable, and synchronised pad input readback.
- Provides rising-edge interrupt capture with per-bit enable and write-1-to-clear status.
- Provides a software-driven LA output bank.
- IO count, LA width, IRQ count, synchroniser depth and base address are all parameters.

---
 rtl/wb_user_io_pkg.sv | 26 ++
 rtl/io_sync_edge.sv | 46 ++++
 rtl/wb_user_io_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wb_user_io_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_user_io_pkg.sv
// Shared constants for the user-area Wishbone IO block: register offsets,
// ID magic, window size and the 32-bit bank-count helper.
package wb_user_io_pkg;

    localparam int WINDOW_BITS = 8;
    localparam logic [7:0] ID_MAGIC = 8'h5A;

    localparam logic [7:0] OFF_ID       = 8'h00;
    localparam logic [7:0] OFF_OUT      = 8'h10;
    localparam logic [7:0] OFF_OEB      = 8'h20;
    localparam logic [7:0] OFF_IN       = 8'h30;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h40;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h50;
    localparam logic [7:0] OFF_LA_OUT   = 8'h60;
    localparam logic [7:0] OFF_LA_IN    = 8'h70;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    function automatic int num_banks(input int n);
        return (n + 32'sd31) / 32'sd32;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for asynchronous pad inputs plus a history flop
// used to detect rising edges of the synchronised value.
module io_sync_edge #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    // Shift chain: stage 0 samples the pad, the last stage feeds history.
    always_comb begin
        stage_d[0] = async_in;
        for (int s = 1; s < STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
        hist_d = stage_q[STAGES-1];
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= {WIDTH{1'b0}};
            end
            hist_q <= {WIDTH{1'b0}};
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
            hist_q <= hist_d;
        end
    end

    assign sync = stage_q[STAGES-1];
    assign rise = sync & ~hist_q;

endmodule

// File: rtl/wb_user_io_ctrl.sv
// Wishbone slave register block driving user IO pads, the LA output bank and
// user IRQs from rising-edge status bits.
module wb_user_io_ctrl
    import wb_user_io_pkg::*;
#(
    parameter int          NUM_IO      = 38,
    parameter int          NUM_LA      = 128,
    parameter int          NUM_IRQ     = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    input  logic [NUM_IO-1:0]  io_in,
    output logic [NUM_IO-1:0]  io_out,
    output logic [NUM_IO-1:0]  io_oeb,
    input  logic [NUM_LA-1:0]  la_data_in,
    output logic [NUM_LA-1:0]  la_data_out,
    input  logic [NUM_LA-1:0]  la_oenb,
    output logic [NUM_IRQ-1:0] user_irq
);

    localparam int IO_W = num_banks(NUM_IO) * 32;
    localparam int LA_W = num_banks(NUM_LA) * 32;

    logic [NUM_IO-1:0]  out_q, out_d, oeb_q, oeb_d;
    logic [NUM_IO-1:0]  en_q, en_d, stat_q, stat_d;
    logic [NUM_LA-1:0]  la_out_q, la_out_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [31:0]        dat_q, dat_d;
    logic               ack_q, ack_d;
    ack_state_e         state_q, state_d;

    logic [NUM_IO-1:0]  sync_s, rise_s;
    logic               hit_s, accept_s, wr_s, unused_s;
    logic [3:0]         region_s;
    logic [1:0]         bank_s;
    logic [6:0]         shamt_s;
    logic [31:0]        bmask_s, id_s, rd_s;
    logic [IO_W-1:0]    io_wmask_s, io_wdata_s;
    logic [LA_W-1:0]    la_wmask_s, la_wdata_s;

    io_sync_edge #(
        .WIDTH  (NUM_IO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .async_in (io_in),
        .sync     (sync_s),
        .rise     (rise_s)
    );

    assign hit_s    = wbs_cyc_i & wbs_stb_i &
                      (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    assign accept_s = hit_s & (state_q == ST_IDLE);
    assign wr_s     = accept_s & wbs_we_i;
    assign region_s = wbs_adr_i[7:4];
    assign bank_s   = wbs_adr_i[3:2];
    assign shamt_s  = {bank_s, 5'd0};
    assign unused_s = ^wbs_adr_i[1:0];
    assign bmask_s  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign id_s     = {ID_MAGIC, 8'(NUM_IRQ), 8'(NUM_LA), 8'(NUM_IO)};

    // Bank-aligned byte masks; banks past the vector width shift out to zero.
    assign io_wmask_s = IO_W'(bmask_s) << shamt_s;
    assign io_wdata_s = IO_W'(wbs_dat_i & bmask_s) << shamt_s;
    assign la_wmask_s = LA_W'(bmask_s) << shamt_s;
    assign la_wdata_s = LA_W'(wbs_dat_i & bmask_s) << shamt_s;

    // Ack FSM: one ack cycle, then a mandatory idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = hit_s ? ST_ACK : ST_IDLE;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);
    end

    // Register writes; a rise on the same cycle as a W1C keeps the bit set.
    always_comb begin
        out_d    = out_q;
        oeb_d    = oeb_q;
        en_d     = en_q;
        la_out_d = la_out_q;
        stat_d   = stat_q | rise_s;
        if (wr_s) begin
            case (region_s)
                OFF_OUT[7:4]:      out_d    = NUM_IO'((IO_W'(out_q) & ~io_wmask_s) | io_wdata_s);
                OFF_OEB[7:4]:      oeb_d    = NUM_IO'((IO_W'(oeb_q) & ~io_wmask_s) | io_wdata_s);
                OFF_IRQ_EN[7:4]:   en_d     = NUM_IO'((IO_W'(en_q) & ~io_wmask_s) | io_wdata_s);
                OFF_IRQ_STAT[7:4]: stat_d   = (stat_q & ~NUM_IO'(io_wdata_s)) | rise_s;
                OFF_LA_OUT[7:4]:   la_out_d = NUM_LA'((LA_W'(la_out_q) & ~la_wmask_s) | la_wdata_s);
                default:           out_d    = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // Read mux over the 32-bit bank selected by the address.
    always_comb begin
        rd_s = 32'd0;
        case (region_s)
            OFF_ID[7:4]:       rd_s = (bank_s == 2'd0) ? id_s : 32'd0;
            OFF_OUT[7:4]:      rd_s = 32'(IO_W'(out_q) >> shamt_s);
            OFF_OEB[7:4]:      rd_s = 32'(IO_W'(oeb_q) >> shamt_s);
            OFF_IN[7:4]:       rd_s = 32'(IO_W'(sync_s) >> shamt_s);
            OFF_IRQ_EN[7:4]:   rd_s = 32'(IO_W'(en_q) >> shamt_s);
            OFF_IRQ_STAT[7:4]: rd_s = 32'(IO_W'(stat_q) >> shamt_s);
            OFF_LA_OUT[7:4]:   rd_s = 32'(LA_W'(la_out_q) >> shamt_s);
            OFF_LA_IN[7:4]:    rd_s = 32'(LA_W'(la_data_in & ~la_oenb) >> shamt_s);
            default:           rd_s = 32'd0;
        endcase
        if (accept_s) begin
            dat_d = rd_s;
        end else begin
            dat_d = 32'd0;
        end
    end

    // IRQ line j collects every enabled status bit i with i mod NUM_IRQ == j.
    always_comb begin
        irq_d = {NUM_IRQ{1'b0}};
        for (int i = 0; i < NUM_IO; i++) begin
            irq_d[i % NUM_IRQ] = irq_d[i % NUM_IRQ] | (stat_q[i] & en_q[i]);
        end
    end

    // State and register file.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            out_q    <= {NUM_IO{1'b0}};
            oeb_q    <= {NUM_IO{1'b1}};
            en_q     <= {NUM_IO{1'b0}};
            stat_q   <= {NUM_IO{1'b0}};
            la_out_q <= {NUM_LA{1'b0}};
            irq_q    <= {NUM_IRQ{1'b0}};
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            out_q    <= out_d;
            oeb_q    <= oeb_d;
            en_q     <= en_d;
            stat_q   <= stat_d;
            la_out_q <= la_out_d;
            irq_q    <= irq_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign io_out      = out_q;
    assign io_oeb      = oeb_q;
    assign la_data_out = la_out_q;
    assign user_irq    = irq_q;

endmodule

// File: tb/tb_wb_user_io_ctrl.sv
// Directed plus randomized bench for wb_user_io_ctrl against a per-cycle
// behavioural model built from the register-map rules.
module tb_wb_user_io_ctrl;

    localparam int NUM_IO = 38;
    localparam int NUM_LA = 128;
    localparam int NUM_IRQ = 3;
    localparam int SYNC_STAGES = 2;

    logic               clk = 1'b0;
    logic               rst, cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, dat;
    logic [31:0]        wbs_dat_o;
    logic               wbs_ack_o;
    logic [NUM_IO-1:0]  io_in, io_out, io_oeb;
    logic [NUM_LA-1:0]  la_data_in, la_data_out, la_oenb;
    logic [NUM_IRQ-1:0] user_irq;

    int checks = 0;
    int errors = 0;

    logic [127:0] out_m, oeb_m, en_m, stat_m, la_m;
    logic [127:0] hq[$];
    logic [31:0]  rd_m, last_rd;
    logic [NUM_IRQ-1:0] irq_m;
    logic         ack_m;

    wb_user_io_ctrl #(
        .NUM_IO(NUM_IO), .NUM_LA(NUM_LA), .NUM_IRQ(NUM_IRQ),
        .SYNC_STAGES(SYNC_STAGES), .BASE_ADDR(32'h3000_0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .la_data_in(la_data_in), .la_data_out(la_data_out), .la_oenb(la_oenb),
        .user_irq(user_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_bank(input logic [127:0] v, input int n, input int bank);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (bank * 32 + k < n) r[k] = v[bank * 32 + k];
        end
        return r;
    endfunction

    function automatic logic [127:0] put_bank(input logic [127:0] v, input int n, input int bank,
                                              input logic [3:0] s, input logic [31:0] d, input bit w1c);
        logic [127:0] r;
        r = v;
        for (int k = 0; k < 32; k++) begin
            if (s[k / 8] && (bank * 32 + k < n)) begin
                if (w1c) begin
                    if (d[k]) r[bank * 32 + k] = 1'b0;
                end else begin
                    r[bank * 32 + k] = d[k];
                end
            end
        end
        return r;
    endfunction

    // Advance one clock: update the model from the inputs seen by this edge,
    // then compare every DUT output just after the edge.
    task automatic tick();
        logic acc;
        int region, bank;
        logic [127:0] sync_v, rise_v;
        logic [31:0] rd;
        logic [NUM_IRQ-1:0] irq_n;
        acc = !rst && cyc && stb && (adr[31:8] == 24'h30_0000) && !ack_m;
        region = int'(adr[7:4]);
        bank = int'(adr[3:2]);
        if (rst) begin
            out_m = 128'd0; oeb_m = (128'd1 << NUM_IO) - 128'd1; en_m = 128'd0;
            stat_m = 128'd0; la_m = 128'd0;
            hq = {};
            for (int i = 0; i <= SYNC_STAGES; i++) hq.push_back(128'd0);
            rd_m = 32'd0; irq_m = '0; ack_m = 1'b0;
        end else begin
            sync_v = hq[SYNC_STAGES-1];
            rise_v = sync_v & ~hq[SYNC_STAGES];
            rd = 32'd0;
            if (acc) begin
                case (region)
                    0: rd = (bank == 0) ? {8'h5A, 8'(NUM_IRQ), 8'(NUM_LA), 8'(NUM_IO)} : 32'd0;
                    1: rd = get_bank(out_m, NUM_IO, bank);
                    2: rd = get_bank(oeb_m, NUM_IO, bank);
                    3: rd = get_bank(sync_v, NUM_IO, bank);
                    4: rd = get_bank(en_m, NUM_IO, bank);
                    5: rd = get_bank(stat_m, NUM_IO, bank);
                    6: rd = get_bank(la_m, NUM_LA, bank);
                    7: rd = get_bank(la_data_in & ~la_oenb, NUM_LA, bank);
                    default: rd = 32'd0;
                endcase
            end
            irq_n = '0;
            for (int i = 0; i < NUM_IO; i++) begin
                if (stat_m[i] && en_m[i]) irq_n[i % NUM_IRQ] = 1'b1;
            end
            if (acc && we) begin
                case (region)
                    1: out_m = put_bank(out_m, NUM_IO, bank, sel, dat, 1'b0);
                    2: oeb_m = put_bank(oeb_m, NUM_IO, bank, sel, dat, 1'b0);
                    4: en_m = put_bank(en_m, NUM_IO, bank, sel, dat, 1'b0);
                    5: stat_m = put_bank(stat_m, NUM_IO, bank, sel, dat, 1'b1);
                    6: la_m = put_bank(la_m, NUM_LA, bank, sel, dat, 1'b0);
                    default: ;
                endcase
            end
            stat_m = stat_m | rise_v;
            hq.push_front(128'(io_in));
            void'(hq.pop_back());
            rd_m = rd; irq_m = irq_n; ack_m = acc;
        end
        @(posedge clk);
        #1;
        chk("ack", 128'(wbs_ack_o), 128'(ack_m));
        chk("dat_o", 128'(wbs_dat_o), 128'(rd_m));
        chk("io_out", 128'(io_out), 128'(out_m[NUM_IO-1:0]));
        chk("io_oeb", 128'(io_oeb), 128'(oeb_m[NUM_IO-1:0]));
        chk("la_out", la_data_out, la_m);
        chk("user_irq", 128'(user_irq), 128'(irq_m));
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        drive(a, w, s, d);
        tick();
        last_rd = wbs_dat_o;
        idle_bus();
        tick();
    endtask

    initial begin
        logic [5:0] acks;
        int nack;
        logic [63:0] flip;
        logic [31:0] a;
        rst = 1'b1; idle_bus(); adr = 32'd0; dat = 32'd0;
        io_in = '0; la_data_in = '0; la_oenb = '0;
        ack_m = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset values and ID register
        access(32'h3000_0000, 1'b0, 4'hF, 32'd0);
        chk("id", 128'(last_rd), 128'h5A03_8026);
        chk("oeb_reset", 128'(io_oeb), 128'h3F_FFFF_FFFF);
        chk("out_reset", 128'(io_out), 128'd0);
        chk("irq_reset", 128'(user_irq), 128'd0);

        // Byte-select writes and the partial upper bank
        access(32'h3000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        chk("out_sel", 128'(io_out[31:0]), 128'h0000_BEEF);
        access(32'h3000_0014, 1'b1, 4'hF, 32'h0000_00FF);
        chk("out_hi", 128'(io_out[37:32]), 128'h3F);
        access(32'h3000_0014, 1'b0, 4'hF, 32'd0);
        chk("out_hi_rd", 128'(last_rd), 128'h3F);

        // Held strobe: ack every other cycle
        drive(32'h3000_0030, 1'b0, 4'hF, 32'd0);
        acks[0] = wbs_ack_o;
        for (int i = 1; i < 6; i++) begin
            tick();
            acks[i] = wbs_ack_o;
        end
        idle_bus(); tick();
        chk("held_stb", 128'(acks), 128'(6'b101010));
        drive(32'h3000_0100, 1'b0, 4'hF, 32'd0);
        nack = 0;
        repeat (4) begin
            tick();
            if (wbs_ack_o) nack++;
        end
        idle_bus(); tick();
        chk("outside_window", 128'(nack), 128'd0);

        // Rising edge on io_in[4] with IRQ enabled, then W1C
        access(32'h3000_0040, 1'b1, 4'hF, 32'h0000_0010);
        io_in[4] = 1'b1;
        tick(); tick(); tick();
        chk("irq_early", 128'(user_irq), 128'd0);
        tick();
        chk("irq1_set", 128'(user_irq), 128'b010);
        access(32'h3000_0050, 1'b0, 4'hF, 32'd0);
        chk("stat4", 128'(last_rd), 128'h10);
        access(32'h3000_0050, 1'b1, 4'hF, 32'h0000_0010);
        chk("irq1_clr", 128'(user_irq), 128'd0);

        // Rise and W1C of bit 7 on the same edge: set wins
        io_in[7] = 1'b1;
        tick(); tick();
        drive(32'h3000_0050, 1'b1, 4'hF, 32'h0000_0080);
        tick();
        idle_bus(); tick();
        access(32'h3000_0050, 1'b0, 4'hF, 32'd0);
        chk("stat7_setwins", 128'(last_rd), 128'h80);
        access(32'h3000_0050, 1'b1, 4'hF, 32'h0000_0080);
        access(32'h3000_0050, 1'b0, 4'hF, 32'd0);
        chk("stat7_clr", 128'(last_rd), 128'h0);

        // Reset on the edge that would accept a write aborts it
        access(32'h3000_0010, 1'b1, 4'hF, 32'd0);
        drive(32'h3000_0010, 1'b1, 4'hF, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();
        chk("rst_no_ack", 128'(wbs_ack_o), 128'd0);
        chk("rst_out", 128'(io_out), 128'd0);
        rst = 1'b0;
        drive(32'h3000_0010, 1'b0, 4'hF, 32'd0);
        tick();
        chk("post_rst_ack", 128'(wbs_ack_o), 128'd1);
        chk("post_rst_dat", 128'(wbs_dat_o), 128'd0);
        idle_bus(); tick();

        // Randomized traffic against the model
        for (int it = 0; it < 200; it++) begin
            flip = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            io_in = io_in ^ flip[NUM_IO-1:0];
            la_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            la_oenb = {$urandom(), $urandom(), $urandom(), $urandom()};
            a = 32'h3000_0000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_0100;
            access(a, 1'($urandom_range(0, 1)), 4'($urandom()), $urandom());
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
